// File: rtl/mult_eval_sequencer.sv
// rtl/mult_eval_sequencer.sv - stimulus/check sequencer that scores a combinational multiplier candidate
// Drives operand pairs, waits a settle time, compares the product against a golden value, keeps stats.
module mult_eval_sequencer #(
   parameter int          WIDTH         = 2,
   parameter int          NUM_VECTORS   = 20,
   parameter int          SETTLE_CYCLES = 1,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 mode,
   input  logic                 abort,
   output logic [WIDTH-1:0]     mult_a,
   output logic [WIDTH-1:0]     mult_b,
   input  logic [2*WIDTH-1:0]   mult_p,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [15:0]          vec_count,
   output logic [15:0]          err_count,
   output logic [WIDTH-1:0]     fail_a,
   output logic [WIDTH-1:0]     fail_b,
   output logic [2*WIDTH-1:0]   fail_p,
   output logic                 fail_valid
);

   localparam int          PW          = 2 * WIDTH;
   localparam logic [15:0] SEED        = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [15:0] EXH_LAST    = 16'((32'd1 << PW) - 32'd1);
   localparam logic [15:0] RND_LAST    = 16'(NUM_VECTORS - 1);
   localparam logic [3:0]  SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_SETTLE,
      S_CHECK,
      S_DONE
   } state_t;

   state_t           state;
   logic             mode_r;
   logic [15:0]      lfsr;
   logic [15:0]      idx;
   logic [3:0]       settle_cnt;
   logic [PW-1:0]    expected;

   logic [WIDTH-1:0] vec_a;
   logic [WIDTH-1:0] vec_b;
   logic [PW-1:0]    golden;
   logic [15:0]      lfsr_next;
   logic             is_last;
   logic             mismatch;

   // Exhaustive mode walks the index; random mode takes operands straight from the LFSR.
   assign vec_a     = mode_r ? idx[WIDTH-1:0]  : lfsr[WIDTH-1:0];
   assign vec_b     = mode_r ? idx[PW-1:WIDTH] : lfsr[PW-1:WIDTH];
   assign golden    = PW'(vec_a) * PW'(vec_b);
   assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign is_last   = (idx == (mode_r ? EXH_LAST : RND_LAST));
   assign mismatch  = (mult_p != expected);
   assign pass      = done && (err_count == 16'h0000);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         mode_r     <= 1'b0;
         lfsr       <= SEED;
         idx        <= 16'h0000;
         settle_cnt <= 4'd0;
         expected   <= '0;
         mult_a     <= '0;
         mult_b     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         vec_count  <= 16'h0000;
         err_count  <= 16'h0000;
         fail_a     <= '0;
         fail_b     <= '0;
         fail_p     <= '0;
         fail_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state      <= S_APPLY;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  mode_r     <= mode;
                  lfsr       <= SEED;
                  idx        <= 16'h0000;
                  vec_count  <= 16'h0000;
                  err_count  <= 16'h0000;
                  fail_a     <= '0;
                  fail_b     <= '0;
                  fail_p     <= '0;
                  fail_valid <= 1'b0;
               end
            end
            S_APPLY: begin
               if (abort) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  mult_a   <= vec_a;
                  mult_b   <= vec_b;
                  expected <= golden;
                  if (SETTLE_CYCLES > 0) begin
                     settle_cnt <= SETTLE_LAST;
                     state      <= S_SETTLE;
                  end else begin
                     state <= S_CHECK;
                  end
               end
            end
            S_SETTLE: begin
               if (abort) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else if (settle_cnt == 4'd0) begin
                  state <= S_CHECK;
               end else begin
                  settle_cnt <= settle_cnt - 4'd1;
               end
            end
            S_CHECK: begin
               if (abort) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  vec_count <= vec_count + 16'd1;
                  if (mismatch) begin
                     if (err_count != 16'hFFFF)
                        err_count <= err_count + 16'd1;
                     // Only the first failing vector is kept for debug.
                     if (!fail_valid) begin
                        fail_a     <= mult_a;
                        fail_b     <= mult_b;
                        fail_p     <= mult_p;
                        fail_valid <= 1'b1;
                     end
                  end
                  lfsr <= lfsr_next;
                  idx  <= idx + 16'd1;
                  if (is_last) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= S_APPLY;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_eval_sequencer.sv
// tb/tb_mult_eval_sequencer.sv - scoreboard bench for mult_eval_sequencer
module tb_mult_eval_sequencer;

   localparam int W  = 2;
   localparam int PW = 4;

   typedef struct {
      int a;
      int b;
   } vec_t;

   typedef struct {
      int vc;
      int ec;
      int ps;
      int fv;
      int fa;
      int fb;
      int fp;
      int lat;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic mode = 1'b0;
   logic abort = 1'b0;
   logic stuck = 1'b0;
   logic start0 = 1'b0;

   logic [W-1:0]  a1, b1, fa1, fb1;
   logic [PW-1:0] p1, fp1;
   logic          busy1, done1, pass1, fv1;
   logic [15:0]   vc1, ec1;

   logic [W-1:0]  a0, b0, fa0, fb0;
   logic [PW-1:0] p0, fp0;
   logic          busy0, done0, pass0, fv0;
   logic [15:0]   vc0, ec0;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   start_edge1 = 0;
   int   start_edge0 = 0;
   vec_t vq1[$];
   vec_t vq0[$];
   res_t rq1[$];
   res_t rq0[$];
   logic [15:0] pvc1 = 16'h0;
   logic [15:0] pvc0 = 16'h0;
   logic        pd1 = 1'b0;
   logic        pd0 = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Candidate multipliers: dut gets an optional P[0] stuck-at-0 fault.
   assign p1 = (PW'(a1) * PW'(b1)) & {{(PW-1){1'b1}}, ~stuck};
   assign p0 = PW'(a0) * PW'(b0);

   mult_eval_sequencer #(.WIDTH(W), .NUM_VECTORS(20), .SETTLE_CYCLES(1), .LFSR_SEED(16'hACE1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
      .mult_a(a1), .mult_b(b1), .mult_p(p1), .busy(busy1), .done(done1), .pass(pass1),
      .vec_count(vc1), .err_count(ec1), .fail_a(fa1), .fail_b(fb1), .fail_p(fp1), .fail_valid(fv1)
   );

   mult_eval_sequencer #(.WIDTH(W), .NUM_VECTORS(20), .SETTLE_CYCLES(0), .LFSR_SEED(16'hACE1)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .mode(1'b1), .abort(1'b0),
      .mult_a(a0), .mult_b(b0), .mult_p(p0), .busy(busy0), .done(done0), .pass(pass0),
      .vec_count(vc0), .err_count(ec0), .fail_a(fa0), .fail_b(fb0), .fail_p(fp0), .fail_valid(fv0)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   function automatic int lfsr_step(input int l);
      int fb;
      fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
      return ((l << 1) & 'hFFFF) | fb;
   endfunction

   // Reference model: vector order and run statistics straight from the operating rules.
   task automatic plan1(input bit rnd, input bit stk, input bit push_res);
      int   n;
      int   l;
      int   prod;
      int   obs;
      vec_t v;
      res_t r;
      n = rnd ? 20 : 16;
      l = 'hACE1;
      r = '{default: 0};
      for (int k = 0; k < n; k++) begin
         v.a = rnd ? (l % 4) : (k % 4);
         v.b = rnd ? ((l / 4) % 4) : (k / 4);
         vq1.push_back(v);
         prod = v.a * v.b;
         obs  = stk ? (prod & 'hE) : prod;
         if (obs != prod) begin
            r.ec++;
            if (r.fv == 0) begin
               r.fv = 1;
               r.fa = v.a;
               r.fb = v.b;
               r.fp = obs;
            end
         end
         l = lfsr_step(l);
      end
      r.vc  = n;
      r.ps  = (r.ec == 0) ? 1 : 0;
      r.lat = n * 3;
      if (push_res) rq1.push_back(r);
   endtask

   task automatic plan0();
      vec_t v;
      res_t r;
      r = '{default: 0};
      for (int k = 0; k < 16; k++) begin
         v.a = k % 4;
         v.b = k / 4;
         vq0.push_back(v);
      end
      r.vc  = 16;
      r.ps  = 1;
      r.lat = 32;
      rq0.push_back(r);
   endtask

   task automatic go1(input bit m);
      @(negedge clk);
      mode  = m;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      start_edge1 = cyc;
   endtask

   task automatic wait_done1(input int maxc);
      int n;
      n = 0;
      while (!done1 && n < maxc) begin
         @(posedge clk);
         n++;
      end
      if (!done1) chk("timeout_dut", 0, 1);
      @(negedge clk);
      #1;
   endtask

   // Monitors: pop the scoreboard whenever a vector is retired or a run completes.
   always @(negedge clk) begin
      if (rst_n && vc1 == pvc1 + 16'd1) begin
         if (vq1.size() == 0) chk("dut_unexpected_vector", 1, 0);
         else begin
            chk("dut_vec_a", int'(a1), vq1[0].a);
            chk("dut_vec_b", int'(b1), vq1[0].b);
            void'(vq1.pop_front());
         end
      end
      if (rst_n && done1 && !pd1) begin
         if (rq1.size() == 0) chk("dut_unexpected_done", 1, 0);
         else begin
            chk("dut_vec_count", int'(vc1), rq1[0].vc);
            chk("dut_err_count", int'(ec1), rq1[0].ec);
            chk("dut_pass", int'(pass1), rq1[0].ps);
            chk("dut_fail_valid", int'(fv1), rq1[0].fv);
            chk("dut_fail_a", int'(fa1), rq1[0].fa);
            chk("dut_fail_b", int'(fb1), rq1[0].fb);
            chk("dut_fail_p", int'(fp1), rq1[0].fp);
            chk("dut_done_latency", cyc - start_edge1, rq1[0].lat);
            void'(rq1.pop_front());
         end
      end
      pvc1 <= vc1;
      pd1  <= done1;
   end

   always @(negedge clk) begin
      if (rst_n && vc0 == pvc0 + 16'd1) begin
         if (vq0.size() == 0) chk("dut0_unexpected_vector", 1, 0);
         else begin
            chk("dut0_vec_a", int'(a0), vq0[0].a);
            chk("dut0_vec_b", int'(b0), vq0[0].b);
            void'(vq0.pop_front());
         end
      end
      if (rst_n && done0 && !pd0) begin
         if (rq0.size() == 0) chk("dut0_unexpected_done", 1, 0);
         else begin
            chk("dut0_vec_count", int'(vc0), rq0[0].vc);
            chk("dut0_err_count", int'(ec0), rq0[0].ec);
            chk("dut0_pass", int'(pass0), rq0[0].ps);
            chk("dut0_done_latency", cyc - start_edge0, rq0[0].lat);
            void'(rq0.pop_front());
         end
      end
      pvc0 <= vc0;
      pd0  <= done0;
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_ab"}, int'({a1, b1}), 0);
      chk({tag, "_busy_done_pass"}, int'({busy1, done1, pass1}), 0);
      chk({tag, "_counts"}, int'(vc1) + int'(ec1), 0);
      chk({tag, "_fail_fields"}, int'({fv1, fa1, fb1, fp1}), 0);
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1 chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Exhaustive, ideal multiplier.
      plan1(1'b0, 1'b0, 1'b1);
      go1(1'b1);
      chk("busy_after_start", int'(busy1), 1);
      wait_done1(200);

      // Exhaustive with P[0] stuck at 0.
      stuck = 1'b1;
      plan1(1'b0, 1'b1, 1'b1);
      go1(1'b1);
      wait_done1(200);
      stuck = 1'b0;

      // Random mode twice: identical sequence, counters cleared on restart.
      plan1(1'b1, 1'b0, 1'b1);
      go1(1'b0);
      chk("restart_clears_err", int'(ec1), 0);
      chk("restart_clears_fv", int'(fv1), 0);
      wait_done1(200);
      plan1(1'b1, 1'b0, 1'b1);
      go1(1'b0);
      chk("restart_clears_vc", int'(vc1), 0);
      wait_done1(200);

      // Abort (with a simultaneous start) during the 6th vector's settle cycle.
      plan1(1'b0, 1'b0, 1'b0);
      go1(1'b1);
      repeat (16) @(posedge clk);
      #1 abort = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      start = 1'b0;
      chk("abort_busy", int'(busy1), 0);
      chk("abort_done", int'(done1), 0);
      chk("abort_vec_count", int'(vc1), 5);
      repeat (3) @(posedge clk);
      #1 chk("abort_stays_idle", int'({busy1, done1}), 0);
      chk("abort_remaining_vectors", vq1.size(), 11);
      vq1.delete();
      plan1(1'b0, 1'b0, 1'b1);
      go1(1'b1);
      wait_done1(200);

      // Start pulsed while busy must not restart the run.
      plan1(1'b0, 1'b0, 1'b1);
      go1(1'b1);
      repeat (10) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done1(200);

      // Asynchronous reset mid-run, between clock edges.
      plan1(1'b0, 1'b0, 1'b0);
      go1(1'b1);
      repeat (7) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk_zero("async_reset");
      vq1.delete();
      #2 rst_n = 1'b1;
      plan1(1'b0, 1'b0, 1'b1);
      go1(1'b1);
      wait_done1(200);

      // Zero settle cycles.
      plan0();
      @(negedge clk);
      start0 = 1'b1;
      @(posedge clk);
      #1 start0 = 1'b0;
      start_edge0 = cyc;
      n = 0;
      while (!done0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (!done0) chk("timeout_dut0", 0, 1);
      @(negedge clk);
      #1;

      chk("scoreboard_vectors_drained", vq1.size() + vq0.size(), 0);
      chk("scoreboard_results_drained", rq1.size() + rq0.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mult_eval_sequencer.md
Name: mult_eval_sequencer

Overview:
- Self-checking stimulus controller for the combinational `multiplier` datapath (ports A, B, P) used in design-space exploration.
- Drives operand pairs into a candidate multiplier, waits a programmable settle time, samples the product and compares it with an internal golden product.
- Accumulates error statistics so the exploration loop can score a candidate without running a simulator-side testbench.
- Sits beside the candidate multiplier instance. Only the operand and product buses connect to it.

Parameters:
- WIDTH, 2: operand width in bits; legal range 1..8, so 2*WIDTH <= 16.
- NUM_VECTORS, 20: vector count in random mode; legal range 1..65535.
- SETTLE_CYCLES, 1: cycles between operand apply and product sample; legal range 0..15.
- LFSR_SEED, 16'hACE1: random-mode seed; a value of 0 is replaced by 16'h0001.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begins a run; honoured only in IDLE or DONE.
- mode  in  1  0 = random (LFSR), 1 = exhaustive; sampled on the accepted start.
- abort  in  1  ends a run and returns to IDLE without asserting done.
- mult_a  out  WIDTH  operand A to the multiplier (registered).
- mult_b  out  WIDTH  operand B to the multiplier (registered).
- mult_p  in  2*WIDTH  product from the multiplier.
- busy  out  1  high in APPLY, SETTLE and CHECK.
- done  out  1  high while in DONE.
- pass  out  1  done && err_count == 0.
- vec_count  out  16  vectors checked in the current or last run.
- err_count  out  16  mismatches; saturates at 16'hFFFF.
- fail_a  out  WIDTH  A of the first mismatching vector.
- fail_b  out  WIDTH  B of the first mismatching vector.
- fail_p  out  2*WIDTH  observed P of the first mismatch.
- fail_valid  out  1  fail_* fields hold a capture.

Behaviour:
- Reset (asynchronous, active-low): state = IDLE; every output and every counter = 0; LFSR = seed.
- States and transitions:
  - IDLE: on start → APPLY.
  - APPLY: 1 cycle; registers vector k onto mult_a/mult_b and registers expected = A*B (2*WIDTH bits, unsigned, never truncated). Next state is SETTLE if SETTLE_CYCLES > 0, otherwise CHECK.
  - SETTLE: exactly SETTLE_CYCLES cycles, then CHECK.
  - CHECK: 1 cycle; compares mult_p with expected and increments vec_count. Next state is APPLY if more vectors remain, otherwise DONE.
  - DONE: holds all results. start → APPLY as a new run; abort has no effect.
- Accepted start:
  - clears vec_count, err_count, fail_valid and fail_*.
  - reloads the LFSR with the seed and resets the index counter to 0.
  - latches mode.
- start while busy is ignored.
- abort in any busy state → IDLE next cycle:
  - counters keep their partial values; done stays 0.
  - abort has priority over start in the same cycle.
- Vector generation:
  - Exhaustive: index idx runs 0 .. 2^(2*WIDTH)-1; mult_a = idx[WIDTH-1:0], mult_b = idx[2*WIDTH-1:WIDTH]. Run length is 2^(2*WIDTH); NUM_VECTORS is ignored.
  - Random: 16-bit Fibonacci LFSR, shift left, feedback bit0 = l[15]^l[13]^l[12]^l[10]. Vector 0 uses the seed. The LFSR advances once per CHECK. mult_a = l[WIDTH-1:0], mult_b = l[2*WIDTH-1:WIDTH]. Run length is NUM_VECTORS.
- Mismatch in CHECK:
  - err_count increments, saturating at 16'hFFFF.
  - If fail_valid = 0: capture mult_a, mult_b, mult_p into fail_*, and set fail_valid = 1.
- Timing:
  - Per vector: 2 + SETTLE_CYCLES cycles.
  - done rises N*(2 + SETTLE_CYCLES) cycles after the start-sampling edge, where N is the run length.
- mult_a/mult_b remain stable from APPLY through CHECK. They hold their last value in DONE and IDLE.

Test Plan:
- WIDTH=2, SETTLE_CYCLES=1, exhaustive, ideal multiplier → vec_count=16, err_count=0, pass=1, done high 48 cycles after start, fail_valid=0.
- Same setup, multiplier with P[0] stuck at 0 → err_count=4 (vectors idx 5, 7, 13, 15). First capture: fail_a=1, fail_b=1, fail_p=0, fail_valid=1. pass=0.
- Random mode, seed 16'hACE1, NUM_VECTORS=20, ideal multiplier → the 20 (A,B) pairs match a bench LFSR model; vec_count=20, pass=1. A second start reproduces the identical sequence and clears the counters first.
- Exhaustive run, abort asserted during the 6th vector's SETTLE → IDLE next cycle, done=0, vec_count=5. A new start then completes normally with 16 vectors.
- rst_n pulled low mid-run (asynchronous, between clock edges) → all outputs 0 immediately; after release, a start runs cleanly. start pulsed while busy → no restart, and the vector order is unchanged.
- SETTLE_CYCLES=0, exhaustive, ideal multiplier → per-vector period 2 cycles, done 32 cycles after start; the mismatch count stays 0.
